// File: rtl/fpu_issue_stage.sv
// fpu_issue_stage: producer side of the EXE operand interface.
// Decodes 32-bit FPU instructions, reads operands from a local register
// file and drives numberA/numberB/Flags into EXE. EXE results come back
// through the writeback port. A per-register pending scoreboard blocks
// RAW/WAW hazards until the matching writeback arrives.
// Optional build macro: FPU_WB_BYPASS_EN forwards same-cycle writeback data
// into the hazard check and the operand read, removing the writeback stall.
module fpu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              exe_ready,
    output logic              issue_valid,
    output logic [DATA_W-1:0] numberA,
    output logic [DATA_W-1:0] numberB,
    output logic [3:0]        Flags,
    output logic [REG_AW-1:0] issue_rd,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              err,
    output logic              busy
);
    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] rf [NREG];
    logic [NREG-1:0]   pending;

    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [15:0]       imm;
    logic              is_arith;
    logic              is_imm;
    logic              is_lui;

    logic [NREG-1:0]   pend_eff;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm_val;
    logic              stall;
    logic              out_free;
    logic              accept;

    assign opcode   = instr[31:28];
    assign rd       = instr[24 +: REG_AW];
    assign rs1      = instr[20 +: REG_AW];
    assign rs2      = instr[16 +: REG_AW];
    assign imm      = instr[15:0];
    assign is_arith = (opcode[3:2] == 2'b00);
    assign is_lui   = (opcode == 4'd4);
    assign is_imm   = is_lui || (opcode == 4'd5);

    // LUI replaces the whole register; LLI keeps the upper half.
    assign imm_val = is_lui ? {imm, {(DATA_W-16){1'b0}}}
                            : {rf[rd][DATA_W-1:16], imm};

`ifdef FPU_WB_BYPASS_EN
    // Effective pending view and operand read with same-cycle writeback forwarding
    always_comb begin
        pend_eff = pending;
        op_a     = rf[rs1];
        op_b     = rf[rs2];
        if (wb_valid) begin
            pend_eff[wb_rd] = 1'b0;
            if (wb_rd == rs1) op_a = wb_data;
            if (wb_rd == rs2) op_b = wb_data;
        end
    end
`else
    // Effective pending view and operand read straight from the register file
    always_comb begin
        pend_eff = pending;
        op_a     = rf[rs1];
        op_b     = rf[rs2];
    end
`endif

    // Hazard check and instruction handshake; immediates never need the output register
    always_comb begin
        stall = pend_eff[rd];
        if (is_arith) stall = stall | pend_eff[rs1] | pend_eff[rs2];
        out_free = !issue_valid || exe_ready;
        if (!rst_n)        instr_ready = 1'b0;
        else if (is_arith) instr_ready = !stall && out_free;
        else if (is_imm)   instr_ready = !stall;
        else               instr_ready = 1'b1;
    end

    assign accept = instr_valid && instr_ready;

    // Register file: writeback port first, immediate port last so it wins on a shared index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (wb_valid)          rf[wb_rd] <= wb_data;
            if (accept && is_imm)  rf[rd]    <= imm_val;
        end
    end

    // Scoreboard: writeback clears, issue sets; set is written last so it wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (wb_valid)           pending[wb_rd] <= 1'b0;
            if (accept && is_arith) pending[rd]    <= 1'b1;
        end
    end

    // Output register toward EXE: load on arithmetic accept, drain when EXE takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            numberA     <= '0;
            numberB     <= '0;
            Flags       <= 4'b0000;
            issue_rd    <= '0;
        end else if (accept && is_arith) begin
            issue_valid <= 1'b1;
            numberA     <= op_a;
            numberB     <= op_b;
            Flags       <= 4'b0001 << opcode[1:0];
            issue_rd    <= rd;
        end else if (exe_ready) begin
            issue_valid <= 1'b0;
            Flags       <= 4'b0000;
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)                             err <= 1'b0;
        else if (accept && !is_arith && !is_imm) err <= 1'b1;
    end

    assign busy = (|pending) || issue_valid;

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Testbench for fpu_issue_stage: scoreboard of expected EXE operations plus
// per-scenario tasks for handshake, hazard, stall, error and reset behaviour.
module tb_fpu_issue_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
`ifdef FPU_WB_BYPASS_EN
    localparam int WB_LAT = 1;
`else
    localparam int WB_LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              exe_ready;
    logic              issue_valid;
    logic [DATA_W-1:0] numberA;
    logic [DATA_W-1:0] numberB;
    logic [3:0]        Flags;
    logic [REG_AW-1:0] issue_rd;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              err;
    logic              busy;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        logic [3:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t sb_got;
    exp_t sb_want;
    int   total = 0;
    int   bad   = 0;

    fpu_issue_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .exe_ready(exe_ready), .issue_valid(issue_valid),
        .numberA(numberA), .numberB(numberB), .Flags(Flags), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required finish before 500000");
        $fatal(1, "watchdog");
    end

    // Scoreboard: an operation is consumed by EXE when issue_valid & exe_ready at an edge
    always @(negedge clk) begin
        if (rst_n && issue_valid && exe_ready) begin
            total++;
            sb_got = {numberA, numberB, Flags, issue_rd};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got A=%h B=%h F=%b rd=%0d, required no issue",
                         numberA, numberB, Flags, issue_rd);
            end else begin
                sb_want = sb.pop_front();
                if (sb_got !== sb_want) begin
                    bad++;
                    $display("FAIL sb_issue: got A=%h B=%h F=%b rd=%0d, required A=%h B=%h F=%b rd=%0d",
                             sb_got.a, sb_got.b, sb_got.f, sb_got.rd,
                             sb_want.a, sb_want.b, sb_want.f, sb_want.rd);
                end
            end
        end
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Offer an instruction until accepted; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] ins, output int waited);
        instr = ins;
        instr_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: instr=%h ready=%b after %0d cycles, required 1", ins, instr_ready, waited);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] r, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_rd    = r;
        wb_data  = d;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr       = enc(4'd4, 4'd1, 4'd0, 4'd0, 16'h3F00);
        exe_ready   = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (instr_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b, required 0", instr_ready);
        end
        total++;
        if ({issue_valid, numberA, numberB, Flags, issue_rd, err, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got iv=%b A=%h B=%h F=%b rd=%0d err=%b busy=%b, required all 0",
                     issue_valid, numberA, numberB, Flags, issue_rd, err, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr_valid = 1'b0;
    endtask

    task automatic test_arith;
        int w;
        exe_ready = 1'b1;
        send(enc(4'd4, 4'd1, 4'd0, 4'd0, 16'h3F00), w);
        send(enc(4'd4, 4'd2, 4'd0, 4'd0, 16'h3E80), w);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_t'{32'h3F000000, 32'h3E800000, 4'(1 << i), 4'd3});
            send(enc(i[3:0], 4'd3, 4'd1, 4'd2, 16'h0), w);
            @(negedge clk);
            total++;
            if ({issue_valid, Flags, issue_rd, numberA, numberB} !==
                {1'b1, 4'(1 << i), 4'd3, 32'h3F000000, 32'h3E800000}) begin
                bad++;
                $display("FAIL arith_op%0d: got iv=%b F=%b rd=%0d A=%h B=%h, required iv=1 F=%b rd=3 A=3f000000 B=3e800000",
                         i, issue_valid, Flags, issue_rd, numberA, numberB, 4'(1 << i));
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            total++;
            if ({instr_ready, busy, issue_valid, Flags} !== 7'b0100000) begin
                bad++;
                $display("FAIL arith_pending%0d: got ready=%b busy=%b iv=%b F=%b, required ready=0 busy=1 iv=0 F=0000",
                         i, instr_ready, busy, issue_valid, Flags);
            end
            @(posedge clk);
            #1;
            do_wb(4'd3, 32'h3F400000);
        end
    endtask

    task automatic test_hazard;
        int w;
        int lat;
        bit found;
        bit acc;
        logic [31:0] a_seen;
        exe_ready = 1'b1;
        sb.push_back(exp_t'{32'h3F000000, 32'h3E800000, 4'b0001, 4'd3});
        send(enc(4'd0, 4'd3, 4'd1, 4'd2, 16'h0), w);
        sb.push_back(exp_t'{32'h3F400000, 32'h3F000000, 4'b0100, 4'd4});
        instr = enc(4'd2, 4'd4, 4'd3, 4'd1, 16'h0);
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (instr_ready !== 1'b0) begin
                bad++;
                $display("FAIL hazard_stall%0d: ready got %b, required 0", k, instr_ready);
            end
            @(posedge clk);
            #1;
        end
        wb_valid = 1'b1;
        wb_rd    = 4'd3;
        wb_data  = 32'h3F400000;
        found = 1'b0;
        lat = -1;
        a_seen = '0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            acc = instr_valid && instr_ready;
            if (issue_valid) begin
                found = 1'b1;
                lat = k;
                a_seen = numberA;
            end
            @(posedge clk);
            #1;
            wb_valid = 1'b0;
            if (acc) instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        total++;
        if (lat !== WB_LAT) begin
            bad++;
            $display("FAIL hazard_latency: MUL issued %0d cycles after wb, required %0d", lat, WB_LAT);
        end
        total++;
        if (a_seen !== 32'h3F400000) begin
            bad++;
            $display("FAIL hazard_operand: numberA got %h, required 3f400000", a_seen);
        end
        do_wb(4'd4, 32'h0);
    endtask

    task automatic test_exe_stall;
        int w;
        logic [76:0] hold;
        exe_ready = 1'b0;
        sb.push_back(exp_t'{32'h3F000000, 32'h3E800000, 4'b0001, 4'd5});
        send(enc(4'd0, 4'd5, 4'd1, 4'd2, 16'h0), w);
        hold = {1'b1, 32'h3F000000, 32'h3E800000, 4'b0001, 4'd5};
        instr = enc(4'd0, 4'd6, 4'd1, 4'd2, 16'h0);
        instr_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                instr = enc(4'd4, 4'd7, 4'd0, 4'd0, 16'h1234);
                instr_valid = 1'b1;
            end
            if (c == 2) instr_valid = 1'b0;
            @(negedge clk);
            total++;
            if ({issue_valid, numberA, numberB, Flags, issue_rd} !== hold) begin
                bad++;
                $display("FAIL stall_hold%0d: got iv=%b A=%h B=%h F=%b rd=%0d, required iv=1 A=3f000000 B=3e800000 F=0001 rd=5",
                         c, issue_valid, numberA, numberB, Flags, issue_rd);
            end
            total++;
            if (instr_ready !== (c != 0)) begin
                bad++;
                $display("FAIL stall_ready%0d: got %b, required %b", c, instr_ready, (c != 0));
            end
            @(posedge clk);
            #1;
        end
        exe_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({issue_valid, Flags} !== 5'b00000) begin
            bad++;
            $display("FAIL drain: got iv=%b F=%b, required iv=0 F=0000", issue_valid, Flags);
        end
        @(posedge clk);
        #1;
        do_wb(4'd5, 32'h0);
        sb.push_back(exp_t'{32'h12340000, 32'h12340000, 4'b0001, 4'd8});
        send(enc(4'd0, 4'd8, 4'd7, 4'd7, 16'h0), w);
        send(enc(4'd5, 4'd7, 4'd0, 4'd0, 16'hABCD), w);
        sb.push_back(exp_t'{32'h1234ABCD, 32'h3F000000, 4'b0100, 4'd9});
        send(enc(4'd2, 4'd9, 4'd7, 4'd1, 16'h0), w);
        do_wb(4'd8, 32'h0);
        do_wb(4'd9, 32'h0);
    endtask

    task automatic test_illegal;
        int w;
        exe_ready = 1'b1;
        send(32'hA000_0000, w);
        total++;
        if (w !== 0) begin
            bad++;
            $display("FAIL illegal_consume: waited %0d cycles, required 0", w);
        end
        @(negedge clk);
        total++;
        if ({err, issue_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL illegal_err: got err=%b iv=%b busy=%b, required err=1 iv=0 busy=0", err, issue_valid, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_sticky: err got %b, required 1", err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        exe_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_t'{32'h3F000000, 32'h3E800000, 4'(1 << i), 4'(10 + i)});
            instr = enc(i[3:0], 4'(10 + i), 4'd1, 4'd2, 16'h0);
            instr_valid = 1'b1;
            @(negedge clk);
            total++;
            if (instr_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready%0d: got %b, required 1", i, instr_ready);
            end
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) do_wb(4'(10 + i), 32'h0);
    endtask

    task automatic test_reset_midop;
        int w;
        exe_ready = 1'b0;
        send(enc(4'd0, 4'd3, 4'd1, 4'd2, 16'h0), w);
        @(negedge clk);
        total++;
        if ({issue_valid, busy} !== 2'b11) begin
            bad++;
            $display("FAIL midop_pre: got iv=%b busy=%b, required iv=1 busy=1", issue_valid, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({issue_valid, numberA, numberB, Flags, issue_rd, err, busy} !== '0) begin
            bad++;
            $display("FAIL midop_reset: got iv=%b A=%h B=%h F=%b rd=%0d err=%b busy=%b, required all 0",
                     issue_valid, numberA, numberB, Flags, issue_rd, err, busy);
        end
        @(posedge clk);
        #1;
        do_wb(4'd3, 32'h12345678);
        exe_ready = 1'b1;
        sb.push_back(exp_t'{32'h12345678, 32'h12345678, 4'b0001, 4'd5});
        send(enc(4'd0, 4'd5, 4'd3, 4'd3, 16'h0), w);
        @(negedge clk);
        total++;
        if ({issue_valid, numberA, numberB} !== {1'b1, 32'h12345678, 32'h12345678}) begin
            bad++;
            $display("FAIL midop_readback: got iv=%b A=%h B=%h, required iv=1 A=12345678 B=12345678",
                     issue_valid, numberA, numberB);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_hazard();
        test_exe_stall();
        test_illegal();
        test_back_to_back();
        test_reset_midop();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d operations never issued, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_issue_stage.md
Name: fpu_issue_stage

Overview:
- Producer side of the EXE operand interface.
- Accepts 32-bit FPU instructions over a valid/ready handshake and reads operands from a local register file.
- Drives numberA/numberB plus a one-hot Flags vector into EXE.
- Accepts EXE results back through a writeback port; a per-register scoreboard enforces RAW/WAW ordering.

Parameters:
DATA_W, 32, operand/result width (IEEE-754 single)
REG_AW, 4, register index width (2**REG_AW registers)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  instruction accepted when instr_valid & instr_ready
instr  in  32  [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm
exe_ready  in  1  EXE can take a new operation this cycle
issue_valid  out  1  numberA/numberB/Flags hold a valid operation
numberA  out  DATA_W  left operand (reg[rs1])
numberB  out  DATA_W  right operand (reg[rs2])
Flags  out  4  one-hot: [0] add, [1] sub, [2] mul, [3] div
issue_rd  out  REG_AW  destination tag travelling with the operation
wb_valid  in  1  EXE result valid
wb_rd  in  REG_AW  result destination
wb_data  in  DATA_W  result value
err  out  1  sticky illegal-opcode flag
busy  out  1  any scoreboard bit set or issue_valid high

Behaviour:
- Reset, synchronous on rst_n low at a clk edge:
  - All registers = 0, all pending bits = 0.
  - issue_valid = 0, numberA = 0, numberB = 0, Flags = 0, issue_rd = 0, err = 0.
  - instr_ready = 0 during the reset cycle.
  - A reset mid-operation drops any issued-but-unwritten op; later wb_valid still writes the register file, and clearing an already-clear pending bit is a no-op.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV: arithmetic.
  - 4 LUI: rd = {imm, 16'h0}.
  - 5 LLI: rd[15:0] = imm, rd[31:16] unchanged.
  - 6-15: illegal.
- Output register:
  - Free when !issue_valid or exe_ready.
  - Once issue_valid is high, all outputs hold stable until exe_ready is sampled high.
- Hazard stall (arithmetic): stall if pending[rs1] | pending[rs2] | pending[rd].
- Hazard stall (LUI/LLI): stall only if pending[rd].
- instr_ready:
  - Arithmetic: instr_ready = !stall & output register free.
  - LUI/LLI: instr_ready = !stall; they never use the output register.
- Arithmetic accept, 1-cycle latency:
  - Next edge: numberA = reg[rs1], numberB = reg[rs2], Flags = 1<<opcode, issue_rd = rd, issue_valid = 1, pending[rd] set.
- Output drain: when exe_ready is high and no new op is accepted, issue_valid drops to 0 and Flags drops to 0. Flags is always 0 when issue_valid is 0.
- LUI/LLI accept: register written at the next edge; nothing issued to EXE.
- Illegal accept:
  - instr_ready = 1 (the instruction is consumed), err set sticky, no state change.
  - err clears only on reset.
- Writeback: wb_valid writes reg[wb_rd] = wb_data and clears pending[wb_rd] at the edge.
- Same-cycle events:
  - Writeback pending-clear and issue pending-set on the same index: set wins.
  - Writeback and LUI/LLI on the same index: immediate write wins.
  - Writeback and LUI/LLI on different indices: both complete (two write ports).
- Without bypass: an operand whose wb arrives in the same cycle still stalls; the op issues the following cycle, reading the updated register.
- Back-to-back: one arithmetic op per cycle sustained while exe_ready = 1 and no hazards.

Optional Feature:
FPU_WB_BYPASS_EN:
- Defined: the hazard check treats pending[x] as clear when wb_valid & wb_rd == x.
- Defined: a matching operand reads wb_data instead of reg[x], removing the one-cycle writeback stall.
- Undefined: no bypass; the stall rules above apply unchanged.

Test Plan:
- Reset then LUI r1,0x3F00; LUI r2,0x3E80; ADD r3,r1,r2 with exe_ready = 1 -> one cycle after accept: numberA = 0x3F000000, numberB = 0x3E800000, Flags = 4'b0001, issue_rd = 3, issue_valid = 1.
- SUB/MUL/DIV r3,r1,r2 in turn -> Flags = 0010, 0100, 1000 respectively; pending[3] stays set until writeback.
- ADD r3,r1,r2 then MUL r4,r3,r1 -> instr_ready = 0 until wb_valid with wb_rd = 3, wb_data = 0x3F400000.
  - Without bypass: MUL issues 2 cycles after the wb with numberA = 0x3F400000.
  - With FPU_WB_BYPASS_EN: MUL issues 1 cycle after the wb.
- exe_ready = 0 for 3 cycles with issue_valid = 1 -> outputs unchanged for 3 cycles; the next arithmetic instruction sees instr_ready = 0, but an LUI to a non-pending rd is accepted.
- Opcode 4'hA -> consumed in 1 cycle, err = 1 and stays high; issue_valid stays 0; only reset clears err.
- rst_n low while issue_valid = 1 and pending[3] set -> all outputs 0 next edge; a later wb to r3 with 0x12345678 writes r3, and ADD r5,r3,r3 then issues numberA = numberB = 0x12345678.
